// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: clock-enable controller placed in front of the CPU core.
// It conditions the raw step button and run switch (2-flop synchronizer plus
// debounce), then issues single-cycle cpu_ce pulses. Pulses come from a
// manual single step (STEP) or from a free-running divider (RUN). A halt
// request from the CPU latches the HALTED state, which only rst_n clears.
//
// Ports:
//   clk        board clock, all logic on its rising edge
//   rst_n      asynchronous active-low reset
//   btn_step   raw step push-button, active-high, asynchronous to clk
//   sw_run     raw run/step switch, 1 = RUN, asynchronous to clk
//   halt       synchronous halt request from the CPU, active-high
//   cpu_ce     CPU clock-enable, one clk cycle wide per step
//   run_led    high while in RUN
//   halt_led   high while in HALTED
//   tick_count number of cpu_ce pulses issued since reset (wraps)
module cpu_clk_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RUN_DIV         = 25000000,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_step,
  input  logic                 sw_run,
  input  logic                 halt,
  output logic                 cpu_ce,
  output logic                 run_led,
  output logic                 halt_led,
  output logic [CNT_WIDTH-1:0] tick_count
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DIV_W = $clog2(RUN_DIV);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    ST_STEP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t state, next_state;

  logic btn_s1, btn_s2, run_s1, run_s2;
  logic btn_db, run_db, btn_db_q;
  logic [DB_W-1:0]  btn_cnt, run_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             ce_next;
  logic             btn_rise;
  logic             div_last;

  // Two-flop synchronizers for both raw inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn_step;
      btn_s2 <= btn_s1;
      run_s1 <= sw_run;
      run_s2 <= run_s1;
    end
  end

  // Button debounce: the debounced value follows only after DEBOUNCE_CYCLES
  // consecutive samples that differ from it; any matching sample restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db  <= 1'b0;
      btn_cnt <= '0;
    end else if (btn_s2 != btn_db) begin
      if (btn_cnt == DB_LAST) begin
        btn_db  <= btn_s2;
        btn_cnt <= '0;
      end else begin
        btn_cnt <= btn_cnt + 1'b1;
      end
    end else begin
      btn_cnt <= '0;
    end
  end

  // Run switch debounce, same scheme
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_db  <= 1'b0;
      run_cnt <= '0;
    end else if (run_s2 != run_db) begin
      if (run_cnt == DB_LAST) begin
        run_db  <= run_s2;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end else begin
      run_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
    end
  end

  assign btn_rise = btn_db & ~btn_db_q;
  assign div_last = (div_cnt == DIV_LAST);

  // Divider is held at zero outside RUN, so it is already clear on RUN entry
  // and any partial count is dropped when leaving RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (state == ST_RUN) begin
      div_cnt <= div_last ? '0 : div_cnt + 1'b1;
    end else begin
      div_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STEP;
    end else begin
      state <= next_state;
    end
  end

  // Priority: halt, then mode change, then pulse generation.
  always_comb begin
    next_state = state;
    ce_next    = 1'b0;
    case (state)
      ST_STEP: begin
        if (halt) begin
          next_state = ST_HALTED;
        end else if (run_db) begin
          next_state = ST_RUN;
        end else if (btn_rise) begin
          ce_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt) begin
          next_state = ST_HALTED;
        end else if (!run_db) begin
          next_state = ST_STEP;
        end else if (div_last) begin
          ce_next = 1'b1;
        end
      end
      ST_HALTED: begin
        next_state = ST_HALTED;
      end
      default: begin
        next_state = ST_STEP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_ce     <= 1'b0;
      tick_count <= '0;
    end else begin
      cpu_ce <= ce_next;
      if (ce_next) begin
        tick_count <= tick_count + 1'b1;
      end
    end
  end

  assign run_led  = (state == ST_RUN);
  assign halt_led = (state == ST_HALTED);

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
module tb_cpu_clk_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_step = 1'b0;
  logic          sw_run = 1'b0;
  logic          halt = 1'b0;
  logic          cpu_ce;
  logic          run_led;
  logic          halt_led;
  logic [CW-1:0] tick_count;

  cpu_clk_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV(5),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_step(btn_step),
    .sw_run(sw_run),
    .halt(halt),
    .cpu_ce(cpu_ce),
    .run_led(run_led),
    .halt_led(halt_led),
    .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int tick;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic prev_ce = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cpu_ce pulse must match the next expected pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ce <= 1'b0;
    end else begin
      if (cpu_ce) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_tick", 32'(tick_count), e.tick);
        end
        check("ce_single_cycle", 32'(prev_ce), 32'd0);
      end
      prev_ce <= cpu_ce;
    end
  end

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input int t);
    exp_t e;
    e.cyc  = c;
    e.tick = t;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    check("leftover_expected", exp_q.size(), 0);
    exp_q.delete();
    btn_step = 1'b0;
    sw_run   = 1'b0;
    halt     = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    check("rst_cpu_ce", 32'(cpu_ce), 0);
    check("rst_tick", 32'(tick_count), 0);
    check("rst_run_led", 32'(run_led), 0);
    check("rst_halt_led", 32'(halt_led), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    @(posedge clk);
    #1;

    // 1: single step, held button, release and re-press
    do_reset();
    n = cyc;
    btn_step = 1'b1;
    push(n + 7, 1);
    goto(n + 6);
    check("t1_no_early_ce", 32'(cpu_ce), 0);
    goto(n + 20);
    check("t1_held_tick", 32'(tick_count), 1);
    btn_step = 1'b0;
    goto(n + 30);
    btn_step = 1'b1;
    push(n + 37, 2);
    goto(n + 45);
    btn_step = 1'b0;
    goto(n + 55);
    check("t1_drain", exp_q.size(), 0);
    check("t1_tick", 32'(tick_count), 2);

    // 2: 3-cycle glitches with 1-cycle gaps never propagate
    do_reset();
    for (int g = 0; g < 5; g++) begin
      n = cyc;
      btn_step = 1'b1;
      goto(n + 3);
      btn_step = 1'b0;
      goto(n + 4);
    end
    goto(cyc + 15);
    check("t2_tick", 32'(tick_count), 0);

    // 3: RUN mode, pulses every 5 cycles, counter wrap
    do_reset();
    n = cyc;
    sw_run = 1'b1;
    for (int k = 0; k < 17; k++) push(n + 12 + 5 * k, (k + 1) % 16);
    goto(n + 6);
    check("t3_run_led_pre", 32'(run_led), 0);
    goto(n + 7);
    check("t3_run_led", 32'(run_led), 1);
    goto(n + 93);
    check("t3_drain", exp_q.size(), 0);
    check("t3_tick_wrap", 32'(tick_count), 1);

    // 4: halt in the cycle a pulse is due
    goto(n + 96);
    halt = 1'b1;
    goto(n + 97);
    halt = 1'b0;
    check("t4_halt_led", 32'(halt_led), 1);
    check("t4_run_led", 32'(run_led), 0);
    check("t4_ce", 32'(cpu_ce), 0);
    check("t4_tick", 32'(tick_count), 1);
    m = cyc;
    sw_run = 1'b0;
    goto(m + 10);
    btn_step = 1'b1;
    goto(m + 20);
    btn_step = 1'b0;
    sw_run = 1'b1;
    goto(m + 30);
    btn_step = 1'b1;
    goto(m + 40);
    btn_step = 1'b0;
    goto(m + 50);
    check("t4_still_halted", 32'(halt_led), 1);
    check("t4_tick_frozen", 32'(tick_count), 1);

    // 5: leave RUN mid-count; the pulse due as the state changes is dropped
    do_reset();
    n = cyc;
    sw_run = 1'b1;
    push(n + 12, 1);
    goto(n + 10);
    sw_run = 1'b0;
    goto(n + 16);
    check("t5_run_led_hold", 32'(run_led), 1);
    goto(n + 17);
    check("t5_run_led_off", 32'(run_led), 0);
    goto(n + 20);
    btn_step = 1'b1;
    push(n + 27, 2);
    goto(n + 35);
    btn_step = 1'b0;
    goto(n + 45);
    check("t5_drain", exp_q.size(), 0);
    check("t5_tick", 32'(tick_count), 2);

    // 6: async reset mid-debounce and in HALTED
    do_reset();
    n = cyc;
    btn_step = 1'b1;
    push(n + 7, 1);
    goto(n + 10);
    btn_step = 1'b0;
    goto(n + 20);
    btn_step = 1'b1;
    goto(n + 23);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_tick", 32'(tick_count), 0);
    check("t6_async_ce", 32'(cpu_ce), 0);
    check("t6_async_leds", {30'd0, run_led, halt_led}, 0);
    btn_step = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m = cyc;
    btn_step = 1'b1;
    push(m + 7, 1);
    goto(m + 6);
    check("t6_latency_early", 32'(cpu_ce), 0);
    goto(m + 10);
    btn_step = 1'b0;
    goto(m + 20);
    check("t6_drain", exp_q.size(), 0);
    halt = 1'b1;
    goto(m + 21);
    halt = 1'b0;
    check("t6_halted", 32'(halt_led), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_halt_rst_leds", {30'd0, run_led, halt_led}, 0);
    check("t6_halt_rst_tick", 32'(tick_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    goto(cyc + 5);
    check("t6_final_leftover", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
Clock-enable controller that sits directly upstream of the CPU core (main) inside main_visual. It conditions the raw board step button and run switch, then issues single-cycle CPU clock-enable pulses. Pulses come from either manual single-step or a free-running divided rate, so the pc/instr/arg/acc displays can be followed by eye. It also latches a CPU halt request and counts issued pulses for display.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a debounced input changes (10 ms at 50 MHz).
RUN_DIV, 25000000, clk cycles between pulses in RUN mode (2 Hz at 50 MHz); must be >= 2.
CNT_WIDTH, 16, width of the issued-pulse counter.

Ports:
clk  input  1  board clock; all logic on its rising edge.
rst_n  input  1  asynchronous active-low reset.
btn_step  input  1  raw step push-button, active-high, asynchronous to clk.
sw_run  input  1  raw run/step select switch, 1 = RUN, asynchronous to clk.
halt  input  1  synchronous halt request from the CPU, active-high.
cpu_ce  output  1  CPU clock-enable, exactly one clk cycle wide per step.
run_led  output  1  high while in RUN state.
halt_led  output  1  high while in HALTED state.
tick_count  output  CNT_WIDTH  number of cpu_ce pulses issued since reset.

Behaviour:
- Reset (rst_n=0, async): synchronizers, debounced values, debounce counters, divider, cpu_ce, tick_count all 0; state = STEP; run_led=0, halt_led=0. Reset mid-debounce or mid-divide discards all progress.
- Synchronizer: btn_step and sw_run each pass through 2 flops before use.
- Debounce (per input): when the synchronized value differs from the debounced value, the counter increments each cycle. When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced value takes the synchronized value and the counter clears. Any cycle where they match clears the counter. Glitches shorter than DEBOUNCE_CYCLES never propagate.
- Latency: raw btn_step rising at cycle t and held stable gives debounced rise at t+2+DEBOUNCE_CYCLES and cpu_ce high at t+3+DEBOUNCE_CYCLES.
- States (registered):
  STEP: a debounced btn rising edge produces one cpu_ce pulse on the next cycle. Button held produces no further pulses; a release is required. Debounced run=1 moves to RUN.
  RUN: the divider clears on entry and counts 0..RUN_DIV-1. cpu_ce is high in the cycle after the divider reaches RUN_DIV-1, and the divider then wraps to 0. The first pulse therefore comes RUN_DIV cycles after entry. Button edges are ignored. Debounced run=0 moves to STEP; a pending divider count is discarded and no pulse is issued.
  HALTED: no cpu_ce ever. Button and switch are ignored. Exit only via rst_n.
- halt=1 in STEP or RUN moves to HALTED next cycle. Halt has priority over a pulse due in the same cycle: that pulse is suppressed and tick_count is unchanged.
- Simultaneous debounced run change and button edge in STEP: the state transition wins and no step pulse is issued.
- tick_count increments in the cycle cpu_ce is high and wraps from 2^CNT_WIDTH-1 to 0.
- run_led and halt_led are decoded from the registered state. Their reset value is 0.
- cpu_ce is registered and glitch-free; it never stays high two consecutive cycles.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, RUN_DIV=5, CNT_WIDTH=4.)
1. Reset, then btn_step high held 20 cycles from cycle 0 -> cpu_ce high only at cycle 7; tick_count=1; held button gives no more pulses; release then press again -> second pulse, tick_count=2.
2. btn_step glitches high for 3 cycles, repeated 5 times with 1-cycle gaps -> cpu_ce never asserts; tick_count=0.
3. sw_run high, held -> run_led=1 after debounce; pulses every 5 cycles, first exactly 5 cycles after RUN entry; 17 pulses -> tick_count wraps 15 to 0 to 1.
4. In RUN, assert halt 1 cycle in the cycle a pulse is due -> no pulse; halt_led=1, run_led=0; further switch toggles and button presses give no cpu_ce.
5. In RUN, drop sw_run mid-count (divider=3) -> back to STEP after debounce with no stray pulse; the next button press gives exactly one pulse.
6. Assert rst_n=0 asynchronously mid-debounce and in HALTED -> all outputs 0 immediately, state STEP; a full press afterwards takes the complete 7-cycle latency.
